// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined adder/comparator: op encoding and flag bit positions.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_SLT  = 2'b10,
      OP_SLTU = 2'b11
   } alu_op_e;

   localparam int unsigned FLAGS_W = 4;
   localparam int unsigned FLAG_Z  = 3;
   localparam int unsigned FLAG_N  = 2;
   localparam int unsigned FLAG_C  = 1;
   localparam int unsigned FLAG_V  = 0;

endpackage

// File: rtl/alu_adder_seg.sv
// One combinational carry-chain segment: slice + slice + carry-in -> sum slice, carry-out.
module alu_adder_seg
   import alu_pkg::*;
#(
   parameter int unsigned SEG_W = 16
) (
   input  logic [SEG_W-1:0] a,
   input  logic [SEG_W-1:0] b,
   input  logic             ci,
   output logic [SEG_W-1:0] sum_c,
   output logic             co_c
);

   assign {co_c, sum_c} = (SEG_W+1)'(a) + (SEG_W+1)'(b) + (SEG_W+1)'(ci);

endmodule

// File: rtl/alu_adder_pipe.sv
// Segmented-carry pipelined ADD/SUB/SLT/SLTU with valid/ready handshake and sideband tag.
// Define ALU_ADDER_PIPE_FLAGS_EN to build the registered {Z,N,C,V} flags; otherwise flags is tied to 0.
module alu_adder_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in1,
   input  logic [WIDTH-1:0]   in2,
   input  logic [1:0]         op,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out,
   output logic [TAG_W-1:0]   out_tag,
   output logic [FLAGS_W-1:0] flags
);

   localparam int unsigned SEG_W = WIDTH / STAGES;
   localparam int unsigned LAST  = STAGES - 1;
   localparam int unsigned NREG  = (STAGES > 1) ? STAGES - 1 : 1;

   logic adv;

   // Inputs presented to segment k (k=0 straight from the ports, else from register k-1)
   logic             src_v   [STAGES];
   logic [WIDTH-1:0] src_a   [STAGES];
   logic [WIDTH-1:0] src_b   [STAGES];
   logic [WIDTH-1:0] src_sum [STAGES];
   logic [1:0]       src_op  [STAGES];
   logic [TAG_W-1:0] src_tag [STAGES];
   logic             src_ci  [STAGES];
   logic [SEG_W-1:0] seg_sum [STAGES];
   logic             seg_co  [STAGES];
   logic [WIDTH-1:0] nxt_sum [STAGES];

   // Intermediate pipeline registers between segments
   logic             st_v    [NREG];
   logic [WIDTH-1:0] st_a    [NREG];
   logic [WIDTH-1:0] st_b    [NREG];
   logic [WIDTH-1:0] st_sum  [NREG];
   logic [1:0]       st_op   [NREG];
   logic [TAG_W-1:0] st_tag  [NREG];
   logic             st_c    [NREG];

   logic [WIDTH-1:0] fin_sum;
   logic             fin_n;
   logic             fin_v;
   logic             fin_c;
   logic [WIDTH-1:0] res;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv && !rst;

   for (genvar k = 0; k < STAGES; k++) begin : g_seg
      if (k == 0) begin : g_src_in
         // Subtract-type ops invert b and inject the +1 as segment-0 carry-in
         assign src_v[k]   = in_valid && in_ready;
         assign src_a[k]   = in1;
         assign src_b[k]   = (op != OP_ADD) ? ~in2 : in2;
         assign src_sum[k] = '0;
         assign src_op[k]  = op;
         assign src_tag[k] = in_tag;
         assign src_ci[k]  = (op != OP_ADD);
      end else begin : g_src_reg
         assign src_v[k]   = st_v[k-1];
         assign src_a[k]   = st_a[k-1];
         assign src_b[k]   = st_b[k-1];
         assign src_sum[k] = st_sum[k-1];
         assign src_op[k]  = st_op[k-1];
         assign src_tag[k] = st_tag[k-1];
         assign src_ci[k]  = st_c[k-1];
      end

      alu_adder_seg #(
         .SEG_W (SEG_W)
      ) u_seg (
         .a     (src_a[k][k*SEG_W +: SEG_W]),
         .b     (src_b[k][k*SEG_W +: SEG_W]),
         .ci    (src_ci[k]),
         .sum_c (seg_sum[k]),
         .co_c  (seg_co[k])
      );

      // Unfinished slices of src_sum are still zero, so OR merges this segment in
      assign nxt_sum[k] = src_sum[k] | (WIDTH'(seg_sum[k]) << (k * SEG_W));

      if (k < LAST) begin : g_reg
         always_ff @(posedge clk) begin
            if (rst) begin
               st_v[k] <= 1'b0;
            end else if (adv) begin
               st_v[k]   <= src_v[k];
               st_a[k]   <= src_a[k];
               st_b[k]   <= src_b[k];
               st_sum[k] <= nxt_sum[k];
               st_op[k]  <= src_op[k];
               st_tag[k] <= src_tag[k];
               st_c[k]   <= seg_co[k];
            end
         end
      end
   end

   assign fin_sum = nxt_sum[LAST];
   assign fin_c   = seg_co[LAST];
   assign fin_n   = fin_sum[WIDTH-1];
   assign fin_v   = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
                    (fin_sum[WIDTH-1] != src_a[LAST][WIDTH-1]);

   // Result select; compares reuse the subtract's N/V/C
   always_comb begin
      res = fin_sum;
      case (src_op[LAST])
         OP_SLT:  res = WIDTH'(fin_n ^ fin_v);
         OP_SLTU: res = WIDTH'(!fin_c);
         default: res = fin_sum;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out       <= '0;
         out_tag   <= '0;
      end else if (adv) begin
         out_valid <= src_v[LAST];
         out       <= res;
         out_tag   <= src_tag[LAST];
      end
   end

`ifdef ALU_ADDER_PIPE_FLAGS_EN
   logic [FLAGS_W-1:0] flags_nxt;

   always_comb begin
      flags_nxt         = '0;
      flags_nxt[FLAG_Z] = (fin_sum == '0);
      flags_nxt[FLAG_N] = fin_n;
      flags_nxt[FLAG_C] = fin_c;
      flags_nxt[FLAG_V] = fin_v;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags <= '0;
      end else if (adv) begin
         flags <= flags_nxt;
      end
   end
`else
   assign flags = '0;
`endif

endmodule

// File: tb/tb_alu_adder_pipe.sv
// Scoreboard bench for alu_adder_pipe: random and directed ops against an arithmetic reference model.
module tb_alu_adder_pipe;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned STAGES = 2;
   localparam int unsigned TAG_W  = 4;
`ifdef ALU_ADDER_PIPE_FLAGS_EN
   localparam bit FLAGS_ON = 1'b1;
`else
   localparam bit FLAGS_ON = 1'b0;
`endif

   typedef struct {
      logic [31:0] res;
      logic [3:0]  tag;
      logic [3:0]  flg;
      int          acc;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WIDTH-1:0]  in1 = '0;
   logic [WIDTH-1:0]  in2 = '0;
   logic [1:0]        op = 2'b00;
   logic [TAG_W-1:0]  in_tag = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [WIDTH-1:0]  out;
   logic [TAG_W-1:0]  out_tag;
   logic [3:0]        flags;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   last_stall = -1;
   logic rdy_next = 1'b1;
   logic rst_next = 1'b1;
   exp_t q[$];

   alu_adder_pipe #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .TAG_W  (TAG_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in1       (in1),
      .in2       (in2),
      .op        (op),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_tag   (out_tag),
      .flags     (flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on the operands, no carry chain
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] o, input logic [3:0] t);
      exp_t        e;
      longint      sa = longint'($signed(a));
      longint      sb = longint'($signed(b));
      longint      ua = longint'({32'd0, a});
      longint      ub = longint'({32'd0, b});
      longint      sr;
      logic [31:0] sum;
      logic        z, n, c, v;
      if (o == 2'b00) begin
         sum = a + b;
         c   = (ua + ub) > 64'sh0000_0000_FFFF_FFFF;
         sr  = sa + sb;
      end else begin
         sum = a - b;
         c   = (ua >= ub);
         sr  = sa - sb;
      end
      v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      z = (sum == 32'd0);
      n = sum[31];
      case (o)
         2'b10:   e.res = 32'(sa < sb);
         2'b11:   e.res = 32'(ua < ub);
         default: e.res = sum;
      endcase
      e.tag = t;
      e.flg = FLAGS_ON ? {z, n, c, v} : 4'b0000;
      e.acc = 0;
      return e;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // One bench cycle: apply inputs at negedge, record the transfer if it will happen
   task automatic cycle_in(input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] o, input logic [3:0] t, output logic acc);
      exp_t e;
      @(negedge clk);
      rst       = rst_next;
      out_ready = rdy_next;
      in_valid  = v;
      in1       = a;
      in2       = b;
      op        = o;
      in_tag    = t;
      if (rst) q.delete();
      #2;
      acc = v && in_ready;
      if (acc) begin
         e     = model(a, b, o, t);
         e.acc = cyc;
         q.push_back(e);
      end
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] o, input logic [3:0] t);
      logic acc;
      for (int i = 0; i < 100; i++) begin
         cycle_in(1'b1, a, b, o, t, acc);
         if (acc) return;
      end
      check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) cycle_in(1'b0, 32'd0, 32'd0, 2'b00, 4'd0, acc);
   endtask

   task automatic do_reset();
      logic acc;
      rst_next = 1'b1;
      cycle_in(1'b1, 32'h1234_5678, 32'h1, 2'b00, 4'hE, acc);
      check("rst_input_accepted", 32'(acc), 32'd0);
      rst_next = 1'b0;
      cycle_in(1'b0, 32'd0, 32'd0, 2'b00, 4'd0, acc);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out", out, 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      check("rst_flags", 32'(flags), 32'd0);
   endtask

   // Monitor: handshake rule every cycle, head-of-queue compare whenever out_valid
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         check("in_ready", 32'(in_ready), 32'(!rst && (!out_valid || out_ready)));
         if (!out_ready) last_stall = cyc;
         if (!rst && out_valid === 1'b1) begin
            if (q.size() == 0) begin
               check("unexpected_output_tag", 32'(out_tag), 32'hFFFF_FFFF);
            end else begin
               e = q[0];
               check("out", out, e.res);
               check("out_tag", 32'(out_tag), 32'(e.tag));
               check("flags", 32'(flags), 32'(e.flg));
               if (out_ready) begin
                  if (last_stall < e.acc) check("latency", 32'(cyc - e.acc), STAGES);
                  void'(q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      logic acc;
      do_reset();

      // Directed corner ops
      send(32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 4'd3);
      send(32'h8000_0000, 32'h0000_0001, 2'b01, 4'd4);
      send(32'hFFFF_FFFF, 32'h0000_0001, 2'b10, 4'd5);
      send(32'hFFFF_FFFF, 32'h0000_0001, 2'b11, 4'd6);
      send(32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 4'd7);
      send(32'h0000_0005, 32'h0000_0005, 2'b01, 4'd1);
      idle(4);

      // Back-to-back tags 0..7
      for (int t = 0; t < 8; t++) send($urandom, $urandom, 2'(t % 4), 4'(t));
      idle(4);

      // Fill with consumer stalled, keep offering, then release
      rdy_next = 1'b0;
      send(32'h1111_1111, 32'h2222_2222, 2'b00, 4'd8);
      send(32'h3333_3333, 32'h1111_1111, 2'b01, 4'd9);
      for (int i = 0; i < 5; i++) begin
         cycle_in(1'b1, 32'hDEAD_BEEF, 32'h1, 2'b00, 4'd10, acc);
         check("stall_accept", 32'(acc), 32'd0);
      end
      rdy_next = 1'b1;
      idle(4);

      // Reset with two ops in flight; neither may appear afterwards
      rdy_next = 1'b0;
      send(32'hAAAA_0000, 32'h0000_5555, 2'b00, 4'd11);
      send(32'hBBBB_0000, 32'h0000_1111, 2'b01, 4'd12);
      do_reset();
      rdy_next = 1'b1;
      idle(5);

      // Randomised traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         rdy_next = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 4) != 0)
            cycle_in(1'b1, pick(), pick(), 2'($urandom_range(0, 3)), 4'($urandom), acc);
         else
            idle(1);
      end

      rdy_next = 1'b1;
      for (int i = 0; i < 50 && q.size() != 0; i++) idle(1);
      idle(2);
      check("scoreboard_drained", 32'(q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
